// File: rtl/proc_pkg.sv
// Shared opcode encodings, instruction field positions and small decode helpers
// used by the fetch, decode and execute stages.
package proc_pkg;

  localparam int DATA_W = 8;
  localparam int REG_N  = 4;
  localparam int RA_W   = 2;

  // Field slice positions inside the 5-bit low field
  localparam int RT_MSB   = 4;
  localparam int RT_LSB   = 3;
  localparam int IMM5_MSB = 4;
  localparam int IMM3_MSB = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LW   = 3'b011,
    OP_SW   = 3'b100,
    OP_BEQ  = 3'b101,
    OP_J    = 3'b110,
    OP_NOP  = 3'b111
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext3(input logic [2:0] v);
    return {{5{v[2]}}, v};
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI: c.reg_write = 1'b1;
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
      end
      OP_SW:   c.mem_write = 1'b1;
      OP_BEQ:  c.branch    = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers, one write port and two combinational read ports that
// forward same-cycle write-back data.
module regfile4x8
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RA_W-1:0]   raddr_a_i,
  input  logic [RA_W-1:0]   raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) regs_q[i] <= 8'h00;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    if (we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    else                                rdata_a_o = regs_q[raddr_a_i];
    if (we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
    else                                rdata_b_o = regs_q[raddr_b_i];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID and ID/EX pipeline registers, register file access,
// immediate/control decode, jump resolution and load-use stall detection.
module id_stage
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [2:0]  if_opcode,
  input  logic [1:0]  if_rs,
  input  logic [4:0]  if_low5,
  input  logic [7:0]  if_pc_next,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [1:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic        stall_o,
  output logic        jump_o,
  output logic [7:0]  jump_target,
  output logic        ex_valid,
  output logic [2:0]  ex_op,
  output logic [1:0]  ex_rd,
  output logic [7:0]  ex_rs_val,
  output logic [7:0]  ex_rt_val,
  output logic [7:0]  ex_imm,
  output logic [7:0]  ex_pc_next,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch
);

  logic       ifid_valid_q, ifid_valid_d;
  logic [2:0] ifid_op_q, ifid_op_d;
  logic [1:0] ifid_rs_q, ifid_rs_d;
  logic [4:0] ifid_low5_q, ifid_low5_d;
  logic [7:0] ifid_pc_q, ifid_pc_d;

  logic       ex_valid_q, ex_valid_d;
  logic [2:0] ex_op_q, ex_op_d;
  logic [1:0] ex_rd_q, ex_rd_d;
  logic [7:0] ex_rs_val_q, ex_rs_val_d;
  logic [7:0] ex_rt_val_q, ex_rt_val_d;
  logic [7:0] ex_imm_q, ex_imm_d;
  logic [7:0] ex_pc_q, ex_pc_d;
  ctrl_t      ex_ctrl_q, ex_ctrl_d;

  logic [1:0] rt_s;
  logic [7:0] rs_val_s, rt_val_s, imm_s;
  logic       uses_rs_s, uses_rt_s, load_use_s, stall_s, jump_s, issue_s;
  ctrl_t      ctrl_s;

  assign rt_s = ifid_low5_q[RT_MSB:RT_LSB];

  regfile4x8 u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (ifid_rs_q),
    .raddr_b_i (rt_s),
    .rdata_a_o (rs_val_s),
    .rdata_b_o (rt_val_s)
  );

  always_comb begin
    uses_rs_s = 1'b0;
    uses_rt_s = 1'b0;
    imm_s     = sext5(ifid_low5_q[IMM5_MSB:0]);
    case (ifid_op_q)
      OP_ADD, OP_SUB, OP_BEQ: begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
      end
      OP_ADDI: uses_rs_s = 1'b1;
      OP_LW: begin
        uses_rt_s = 1'b1;
        imm_s     = sext3(ifid_low5_q[IMM3_MSB:0]);
      end
      OP_SW: begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
        imm_s     = sext3(ifid_low5_q[IMM3_MSB:0]);
      end
      default: begin
        uses_rs_s = 1'b0;
        uses_rt_s = 1'b0;
      end
    endcase
  end

  assign ctrl_s     = decode_ctrl(ifid_op_q);
  assign load_use_s = ifid_valid_q & ex_valid_q & ex_ctrl_q.mem_read &
                      ((uses_rs_s & (ex_rd_q == ifid_rs_q)) | (uses_rt_s & (ex_rd_q == rt_s)));
  // flush overrides both the stall and the jump redirect
  assign stall_s    = load_use_s & ~flush & ~rst;
  assign jump_s     = ifid_valid_q & (ifid_op_q == OP_J) & ~flush & ~rst;
  assign issue_s    = ifid_valid_q & ~flush & ~stall_s & (ifid_op_q != OP_J);

  assign stall_o     = stall_s;
  assign jump_o      = jump_s;
  assign jump_target = {3'b000, ifid_low5_q};

  always_comb begin
    ifid_valid_d = if_valid;
    ifid_op_d    = if_opcode;
    ifid_rs_d    = if_rs;
    ifid_low5_d  = if_low5;
    ifid_pc_d    = if_pc_next;
    if (flush || jump_s) begin
      ifid_valid_d = 1'b0;
    end else if (stall_s) begin
      ifid_valid_d = ifid_valid_q;
      ifid_op_d    = ifid_op_q;
      ifid_rs_d    = ifid_rs_q;
      ifid_low5_d  = ifid_low5_q;
      ifid_pc_d    = ifid_pc_q;
    end else begin
      ifid_valid_d = if_valid;
    end
  end

  always_comb begin
    ex_valid_d  = issue_s;
    ex_op_d     = ifid_op_q;
    ex_rd_d     = ifid_rs_q;
    ex_rs_val_d = rs_val_s;
    ex_rt_val_d = rt_val_s;
    ex_imm_d    = imm_s;
    ex_pc_d     = ifid_pc_q;
    if (issue_s) ex_ctrl_d = ctrl_s;
    else         ex_ctrl_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_op_q    <= 3'b000;
      ifid_rs_q    <= 2'b00;
      ifid_low5_q  <= 5'b00000;
      ifid_pc_q    <= 8'h00;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_op_q    <= ifid_op_d;
      ifid_rs_q    <= ifid_rs_d;
      ifid_low5_q  <= ifid_low5_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= 3'b000;
      ex_rd_q     <= 2'b00;
      ex_rs_val_q <= 8'h00;
      ex_rt_val_q <= 8'h00;
      ex_imm_q    <= 8'h00;
      ex_pc_q     <= 8'h00;
      ex_ctrl_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      ex_imm_q    <= ex_imm_d;
      ex_pc_q     <= ex_pc_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op        = ex_op_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rs_val    = ex_rs_val_q;
  assign ex_rt_val    = ex_rt_val_q;
  assign ex_imm       = ex_imm_q;
  assign ex_pc_next   = ex_pc_q;
  assign ex_reg_write = ex_ctrl_q.reg_write;
  assign ex_mem_read  = ex_ctrl_q.mem_read;
  assign ex_mem_write = ex_ctrl_q.mem_write;
  assign ex_branch    = ex_ctrl_q.branch;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed expectations for decode, bypass,
// load-use stall, jump, flush and reset behaviour.
module tb_id_stage;
  import proc_pkg::*;

  logic       clk, rst;
  logic       if_valid;
  logic [2:0] if_opcode;
  logic [1:0] if_rs;
  logic [4:0] if_low5;
  logic [7:0] if_pc_next;
  logic       flush, wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       stall_o, jump_o;
  logic [7:0] jump_target;
  logic       ex_valid;
  logic [2:0] ex_op;
  logic [1:0] ex_rd;
  logic [7:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc_next;
  logic       ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_opcode(if_opcode), .if_rs(if_rs),
    .if_low5(if_low5), .if_pc_next(if_pc_next), .flush(flush), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall_o(stall_o), .jump_o(jump_o),
    .jump_target(jump_target), .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_pc_next(ex_pc_next),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] op, input logic [1:0] rs,
                     input logic [4:0] low5, input logic [7:0] pc);
    if_valid   = v;
    if_opcode  = op;
    if_rs      = rs;
    if_low5    = low5;
    if_pc_next = pc;
  endtask

  // ctrl is {reg_write, mem_read, mem_write, branch}
  task automatic chk_ctl(input string tag, input logic v, input logic [3:0] ctrl);
    chk({tag, ".valid"}, {63'd0, ex_valid}, {63'd0, v});
    chk({tag, ".ctrl"}, {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, {60'd0, ctrl});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
    put(1'b0, 3'b000, 2'd0, 5'h00, 8'h00);
    #2;
    chk("rst.stall", {63'd0, stall_o}, 64'd0);
    chk("rst.jump", {63'd0, jump_o}, 64'd0);
    tick; tick;
    chk_ctl("rst", 1'b0, 4'b0000);
    chk("rst.data", {19'd0, ex_op, ex_rd, ex_rs_val, ex_rt_val, ex_imm, ex_pc_next}, 64'd0);
    rst = 1'b0;

    // registers read back as zero after reset
    put(1'b1, OP_ADD, 2'd3, 5'h10, 8'h01); tick;
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h02);
    wb_we = 1'b1; wb_addr = 2'd1; wb_data = 8'h11;
    tick; wb_we = 1'b0;
    chk_ctl("add0", 1'b1, 4'b1000);
    chk("add0.op_rd", {59'd0, ex_op, ex_rd}, {59'd0, 3'b000, 2'd3});
    chk("add0.vals", {48'd0, ex_rs_val, ex_rt_val}, {48'd0, 8'h00, 8'h00});
    chk("add0.pc", {56'd0, ex_pc_next}, {56'd0, 8'h01});

    put(1'b1, OP_ADD, 2'd2, 5'h08, 8'h03); tick;
    chk_ctl("nop", 1'b1, 4'b0000);
    chk("nop.op", {61'd0, ex_op}, {61'd0, 3'b111});

    // write-back to r2 forwarded into the ADD being decoded
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h04);
    wb_we = 1'b1; wb_addr = 2'd2; wb_data = 8'h5A;
    tick; wb_we = 1'b0;
    chk("bypass.vals", {48'd0, ex_rs_val, ex_rt_val}, {48'd0, 8'h5A, 8'h11});

    put(1'b1, OP_ADDI, 2'd0, 5'h1F, 8'h05); tick;
    put(1'b1, OP_SW, 2'd2, 5'h0C, 8'h06); tick;
    chk_ctl("addi", 1'b1, 4'b1000);
    chk("addi.imm", {56'd0, ex_imm}, {56'd0, 8'hFF});
    put(1'b1, OP_LW, 2'd1, 5'h03, 8'h07); tick;
    chk_ctl("sw", 1'b1, 4'b0010);
    chk("sw.imm", {56'd0, ex_imm}, {56'd0, 8'hFC});
    chk("sw.vals", {48'd0, ex_rs_val, ex_rt_val}, {48'd0, 8'h5A, 8'h11});

    // load-use: LW r1 then ADD rs=0, rt=1
    put(1'b1, OP_ADD, 2'd0, 5'h08, 8'h08); tick;
    chk_ctl("lw", 1'b1, 4'b1100);
    chk("lw.imm_rd", {54'd0, ex_imm, ex_rd}, {54'd0, 8'h03, 2'd1});
    chk("lu.stall", {63'd0, stall_o}, 64'd1);
    put(1'b1, OP_BEQ, 2'd3, 5'h1E, 8'h09); tick;
    chk_ctl("lu.bubble", 1'b0, 4'b0000);
    chk("lu.stall_end", {63'd0, stall_o}, 64'd0);
    tick;
    chk_ctl("lu.add", 1'b1, 4'b1000);
    chk("lu.add.vals", {46'd0, ex_rd, ex_rs_val, ex_rt_val}, {46'd0, 2'd0, 8'h00, 8'h11});
    chk("lu.add.pc", {56'd0, ex_pc_next}, {56'd0, 8'h08});

    // jump resolved in decode; the sequential fetch behind it is dropped
    put(1'b1, OP_J, 2'd0, 5'h14, 8'h0A); tick;
    chk_ctl("beq", 1'b1, 4'b0001);
    chk("beq.imm_rd", {54'd0, ex_imm, ex_rd}, {54'd0, 8'hFE, 2'd3});
    chk("j.jump", {63'd0, jump_o}, 64'd1);
    chk("j.target", {56'd0, jump_target}, {56'd0, 8'h14});
    put(1'b1, OP_ADD, 2'd1, 5'h08, 8'h0B); tick;
    chk_ctl("j.bubble", 1'b0, 4'b0000);
    chk("j.jump_end", {63'd0, jump_o}, 64'd0);
    put(1'b1, OP_SUB, 2'd1, 5'h08, 8'h15); tick;
    chk_ctl("j.killed", 1'b0, 4'b0000);
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h16); tick;
    chk_ctl("sub", 1'b1, 4'b1000);
    chk("sub.op_vals", {45'd0, ex_op, ex_rs_val, ex_rt_val}, {45'd0, 3'b001, 8'h11, 8'h11});

    // flush coincident with a load-use stall
    put(1'b1, OP_LW, 2'd2, 5'h00, 8'h20); tick;
    put(1'b1, OP_ADDI, 2'd2, 5'h01, 8'h21); tick;
    chk("fl.stall_pre", {63'd0, stall_o}, 64'd1);
    flush = 1'b1;
    put(1'b1, OP_SW, 2'd0, 5'h00, 8'h22);
    #1;
    chk("fl.stall", {63'd0, stall_o}, 64'd0);
    tick; flush = 1'b0;
    chk_ctl("fl.idex", 1'b0, 4'b0000);
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h23); tick;
    chk_ctl("fl.ifid", 1'b0, 4'b0000);

    // flush suppresses a pending jump
    put(1'b1, OP_J, 2'd0, 5'h03, 8'h24); tick;
    chk("flj.jump_pre", {63'd0, jump_o}, 64'd1);
    flush = 1'b1;
    #1;
    chk("flj.jump", {63'd0, jump_o}, 64'd0);
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h25); tick; flush = 1'b0;

    // reset in the middle of a stall discards the held instruction
    put(1'b1, OP_LW, 2'd0, 5'h00, 8'h30); tick;
    put(1'b1, OP_ADD, 2'd0, 5'h00, 8'h31); tick;
    chk("rs.stall_pre", {63'd0, stall_o}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rs.stall", {63'd0, stall_o}, 64'd0);
    chk_ctl("rs", 1'b0, 4'b0000);
    chk("rs.rd_pc", {54'd0, ex_rd, ex_pc_next}, 64'd0);
    tick; rst = 1'b0;
    put(1'b1, OP_ADD, 2'd1, 5'h10, 8'h40); tick;
    chk_ctl("rs.held_gone", 1'b0, 4'b0000);
    put(1'b1, OP_NOP, 2'd0, 5'h00, 8'h41); tick;
    chk_ctl("rs.add", 1'b1, 4'b1000);
    chk("rs.regs", {40'd0, ex_rs_val, ex_rt_val, ex_pc_next}, {40'd0, 8'h00, 8'h00, 8'h40});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 if_valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-004 if_opcode  input  3  instruction opcode from instruction memory.
REQ-005 if_rs  input  2  rs field (source and destination register).
REQ-006 if_low5  input  5  low field: [4:3] = rt, [4:0] = imm5 or jump target.
REQ-007 if_pc_next  input  8  PC+1 of the fetched instruction, from the PC adder.
REQ-008 flush  input  1  branch taken in EX; kill IF/ID and ID/EX contents.
REQ-009 wb_we, wb_addr, wb_data  input  1/2/8  register-file write-back port.
REQ-010 stall_o  output  1  hold PC and fetch (load-use hazard).
REQ-011 jump_o, jump_target  output  1/8  J resolved in decode; drives PC mux choice and jump input.
REQ-012 ex_valid, ex_op, ex_rd, ex_rs_val, ex_rt_val, ex_imm, ex_pc_next  output  1/3/2/8/8/8/8  registered ID/EX bundle.
REQ-013 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  output  1 each  registered control bits.

Function
REQ-014 Opcodes SHALL be: 000 ADD, 001 SUB, 010 ADDI, 011 LW, 100 SW, 101 BEQ, 110 J, 111 NOP.
REQ-015 IF/ID register SHALL capture {if_valid, opcode, rs, low5, pc_next} each cycle unless stall_o=1 (hold) or flush/jump_o=1 (load valid=0).
REQ-016 Register file SHALL hold 4 x 8-bit registers, one write port (wb), two combinational read ports (rs, rt=low5[4:3]).
REQ-017 Read SHALL bypass: if wb_we=1 and wb_addr equals a read address, that port returns wb_data in the same cycle.
REQ-018 ex_imm SHALL be sign-extended low5 (5->8 bits) for ADDI/BEQ; sign-extended low5[2:0] for LW/SW.
REQ-019 Control: reg_write for ADD,SUB,ADDI,LW; mem_read for LW; mem_write for SW; branch for BEQ; all zero for J, NOP, and invalid slots.
REQ-020 ex_rd SHALL equal rs for every instruction.
REQ-021 J in a valid IF/ID slot SHALL assert jump_o combinationally with jump_target = {3'b000, low5}; next edge loads IF/ID as bubble; J itself enters ID/EX as bubble.
REQ-022 Load-use: stall_o=1 when ex_valid & ex_mem_read and ex_rd equals a register the ID instruction reads (rs for ADD/SUB/ADDI/SW/BEQ; rt for ADD/SUB/LW/SW/BEQ); ID/EX loads a bubble, IF/ID holds.
REQ-023 Stall lasts exactly one cycle per load-use pair.
REQ-024 flush SHALL win over stall and jump: both IF/ID and ID/EX load valid=0 at next edge; stall_o and jump_o forced 0 while flush=1.
REQ-025 Bubble ID/EX SHALL present valid=0 and all control bits 0; data fields don't-care.
REQ-026 Latency: instruction visible at ex_* two edges after presented on if_* when no stall.

Reset
REQ-027 rst SHALL immediately clear IF/ID valid, ex_valid and all ex control bits, all four registers to 8'h00, ex data fields to 0.
REQ-028 stall_o and jump_o SHALL be 0 during reset; reset asserted mid-stall discards the held instruction.

Structure
REQ-029 Opcode encodings and field-slice positions SHALL live in a shared package (proc_pkg) used by fetch, decode and execute.
REQ-030 Register file SHALL be a sub-module named regfile4x8; hazard logic and pipeline registers stay in id_stage.

Verification
REQ-031 Reset: after rst, all ex_* = 0, register reads return 8'h00.
REQ-032 wb_we=1, addr=2, data=8'h5A while decoding ADD rs=2: ex_rs_val=8'h5A (bypass).
REQ-033 LW rs=1 followed by ADD rs=0,rt=1: stall_o=1 one cycle, one bubble in ID/EX, ADD issues next with correct operands.
REQ-034 J low5=5'h14: jump_o=1, jump_target=8'h14; following fetched instruction becomes bubble.
REQ-035 flush=1 coincident with load-use stall: both registers bubble, stall_o=0.
REQ-036 ADDI imm5=5'h1F: ex_imm=8'hFF; SW low5[2:0]=3'b100: ex_imm=8'hFC.
